// File: rtl/vga_wave_disp.sv
// Waveform pixel stage: ping-pong capture of ADC records, plotted as a 3-pixel trace with 2-cycle aligned syncs.
// Optional graticule overlay when GRID_EN is defined.
module vga_wave_disp #(
    parameter int          DEPTH     = 1024,
    parameter int          AW        = 10,
    parameter int          Y_BASE    = 100,
    parameter logic [15:0] TRACE_RGB = 16'h07E0,
    parameter logic [15:0] BG_RGB    = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        pix_en,
    input  logic [10:0] pix_x,
    input  logic [10:0] pix_y,
    input  logic        sample_valid,
    input  logic [7:0]  sample_data,
    input  logic        hold,
    output logic        hs_out,
    output logic        vs_out,
    output logic [15:0] rgb,
    output logic        frame_swap,
    output logic        cap_full
);

    typedef enum logic {S_FILL, S_FULL} state_t;

    state_t          r_state, w_state_nxt;
    logic [AW-1:0]   r_wr_addr, w_wr_addr_nxt;
    logic            r_front, w_front_nxt;
    logic            r_vs_prev;
    logic            r_swap;
    logic            w_swap;
    logic            w_we;
    logic            w_frame_start;

    logic [7:0]      r_mem [0:2*DEPTH-1];
    logic [7:0]      r_dout;

    logic [10:0]     w_col;
    logic            w_inr;
    logic            r_inr1, r_en1, r_hs1, r_vs1;
    logic [10:0]     r_y1;
    logic [10:0]     w_row;
    logic            w_lit;
    logic            r_hs2, r_vs2;
    logic [15:0]     r_rgb;
    logic [15:0]     w_unlit;
`ifdef GRID_EN
    logic            r_grid1;
`endif

    assign w_frame_start = r_vs_prev & ~vs_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FILL;
            r_wr_addr <= '0;
            r_front   <= 1'b0;
            r_vs_prev <= 1'b1;
            r_swap    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_front   <= w_front_nxt;
            r_vs_prev <= vs_in;
            r_swap    <= w_swap;
        end
    end

    // Samples arriving while FULL (including the swap cycle) are dropped.
    always_comb begin
        w_state_nxt   = r_state;
        w_wr_addr_nxt = r_wr_addr;
        w_front_nxt   = r_front;
        w_swap        = 1'b0;
        w_we          = 1'b0;
        case (r_state)
            S_FILL: begin
                if (sample_valid) begin
                    w_we = 1'b1;
                    if (r_wr_addr == AW'(DEPTH - 1)) begin
                        w_state_nxt = S_FULL;
                    end else begin
                        w_wr_addr_nxt = r_wr_addr + 1'b1;
                    end
                end
            end
            S_FULL: begin
                if (w_frame_start && !hold) begin
                    w_swap        = 1'b1;
                    w_front_nxt   = ~r_front;
                    w_wr_addr_nxt = '0;
                    w_state_nxt   = S_FILL;
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    assign w_col = pix_x - 11'd1;
    assign w_inr = pix_en && (w_col < 11'(DEPTH));

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[{~r_front, r_wr_addr}] <= sample_data;
        end
        if (w_inr) begin
            r_dout <= r_mem[{r_front, w_col[AW-1:0]}];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inr1 <= 1'b0;
            r_en1  <= 1'b0;
            r_hs1  <= 1'b1;
            r_vs1  <= 1'b1;
            r_y1   <= '0;
            r_hs2  <= 1'b1;
            r_vs2  <= 1'b1;
            r_rgb  <= '0;
`ifdef GRID_EN
            r_grid1 <= 1'b0;
`endif
        end else begin
            r_inr1 <= w_inr;
            r_en1  <= pix_en;
            r_hs1  <= hs_in;
            r_vs1  <= vs_in;
            r_y1   <= pix_y;
            r_hs2  <= r_hs1;
            r_vs2  <= r_vs1;
`ifdef GRID_EN
            r_grid1 <= (pix_x[5:0] == 6'd0) || (pix_y[5:0] == 6'd0);
`endif
            if (!r_en1)
                r_rgb <= '0;
            else if (w_lit)
                r_rgb <= TRACE_RGB;
            else
                r_rgb <= w_unlit;
        end
    end

    assign w_row = 11'(Y_BASE) + {3'b000, 8'd255 - r_dout};
    // 12-bit compare so row+1 / y+1 cannot wrap.
    assign w_lit = r_inr1 &&
                   ({1'b0, r_y1} + 12'd1 >= {1'b0, w_row}) &&
                   ({1'b0, r_y1} <= {1'b0, w_row} + 12'd1);

`ifdef GRID_EN
    assign w_unlit = r_grid1 ? 16'h4208 : BG_RGB;
`else
    assign w_unlit = BG_RGB;
`endif

    assign hs_out     = r_hs2;
    assign vs_out     = r_vs2;
    assign rgb        = r_rgb;
    assign frame_swap = r_swap;
    assign cap_full   = (r_state == S_FULL);

endmodule

// File: tb/tb_vga_wave_disp.sv
// Directed bench for vga_wave_disp: reset, swap timing, plotting, latency, discard and hold.
module tb_vga_wave_disp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hs_in = 1'b1;
    logic        vs_in = 1'b1;
    logic        pix_en = 1'b0;
    logic [10:0] pix_x = '0;
    logic [10:0] pix_y = '0;
    logic        sample_valid = 1'b0;
    logic [7:0]  sample_data = '0;
    logic        hold = 1'b0;
    logic        hs_out, vs_out, frame_swap, cap_full;
    logic [15:0] rgb;

    int total = 0;
    int bad = 0;
    logic sw;

    localparam logic [15:0] TR = 16'h07E0;
    localparam logic [15:0] BK = 16'h0000;

    vga_wave_disp #(.DEPTH(1024), .AW(10), .Y_BASE(100),
                    .TRACE_RGB(16'h07E0), .BG_RGB(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .hs_in(hs_in), .vs_in(vs_in),
        .pix_en(pix_en), .pix_x(pix_x), .pix_y(pix_y),
        .sample_valid(sample_valid), .sample_data(sample_data), .hold(hold),
        .hs_out(hs_out), .vs_out(vs_out), .rgb(rgb),
        .frame_swap(frame_swap), .cap_full(cap_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic feed(input int n, input bit ramp, input logic [7:0] val);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample_valid = 1'b1;
            sample_data  = ramp ? i[7:0] : val;
            @(negedge clk);
            sample_valid = 1'b0;
        end
    endtask

    // Falling vs edge; reports the pulse on the first cycle and checks it is gone on the next.
    task automatic frame_start(output logic pulse);
        @(negedge clk);
        vs_in = 1'b0;
        @(posedge clk); #1;
        pulse = frame_swap;
        @(posedge clk); #1;
        check("swap_one_cycle", {15'd0, frame_swap}, 16'd0);
        @(negedge clk);
        vs_in = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic pix(input string tag, input int x, input int y, input logic en, input logic [15:0] exp);
        @(negedge clk);
        pix_x  = 11'(x);
        pix_y  = 11'(y);
        pix_en = en;
        @(posedge clk);
        @(posedge clk); #1;
        check(tag, rgb, exp);
        @(negedge clk);
        pix_en = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_hs", {15'd0, hs_out}, 16'd1);
        check("rst_vs", {15'd0, vs_out}, 16'd1);
        check("rst_rgb", rgb, 16'd0);
        check("rst_capfull", {15'd0, cap_full}, 16'd0);
        check("rst_swap", {15'd0, frame_swap}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Mid-stream reset with a full record and syncs active
        feed(1024, 1'b0, 8'h80);
        check("pre_capfull", {15'd0, cap_full}, 16'd1);
        @(negedge clk);
        hold = 1'b1; hs_in = 1'b0; vs_in = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_hs_low", {15'd0, hs_out}, 16'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_hs", {15'd0, hs_out}, 16'd1);
        check("mid_rst_vs", {15'd0, vs_out}, 16'd1);
        check("mid_rst_capfull", {15'd0, cap_full}, 16'd0);
        check("mid_rst_swap", {15'd0, frame_swap}, 16'd0);
        check("mid_rst_rgb", rgb, 16'd0);
        @(negedge clk);
        hold = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Constant record 0x80 -> row 227
        feed(1024, 1'b0, 8'h80);
        check("const_capfull", {15'd0, cap_full}, 16'd1);
        frame_start(sw);
        check("const_swap", {15'd0, sw}, 16'd1);
        check("const_capfull_clr", {15'd0, cap_full}, 16'd0);
        pix("c_r226", 1, 226, 1'b1, TR);
        pix("c_r227", 1, 227, 1'b1, TR);
        pix("c_r228", 1, 228, 1'b1, TR);
        pix("c_x1024", 1024, 227, 1'b1, TR);
        pix("c_r229", 512, 229, 1'b1, BK);
        pix("c_r225", 1, 225, 1'b1, BK);
        pix("c_x1025", 1025, 227, 1'b1, BK);
        pix("c_blank", 1, 227, 1'b0, BK);

        // Ramp record: column 1 -> row 355, column 256 -> row 100
        feed(1024, 1'b1, 8'h00);
        frame_start(sw);
        check("ramp_swap", {15'd0, sw}, 16'd1);
        @(negedge clk);
        pix_x = 11'd1; pix_y = 11'd354; pix_en = 1'b1;
        @(posedge clk); #1;
        check("lat_1cyc", rgb, BK);
        @(posedge clk); #1;
        check("lat_2cyc", rgb, TR);
        @(negedge clk);
        pix_en = 1'b0;
        pix("r_y356", 1, 356, 1'b1, TR);
        pix("r_y357", 1, 357, 1'b1, BK);
        pix("r_x256", 256, 100, 1'b1, TR);
        pix("r_x256_98", 256, 98, 1'b1, BK);
        pix("r_x257", 257, 355, 1'b1, TR);
        @(negedge clk);
        hs_in = 1'b0;
        @(posedge clk); #1;
        check("hs_lag1", {15'd0, hs_out}, 16'd1);
        @(posedge clk); #1;
        check("hs_lag2", {15'd0, hs_out}, 16'd0);
        @(negedge clk);
        hs_in = 1'b1; vs_in = 1'b0;
        @(posedge clk); #1;
        check("vs_lag1", {15'd0, vs_out}, 16'd1);
        @(posedge clk); #1;
        check("vs_lag2", {15'd0, vs_out}, 16'd0);
        @(negedge clk);
        vs_in = 1'b1;
        repeat (3) @(negedge clk);

        // Partial record 0x10 (row 339): no swap until complete
        feed(500, 1'b0, 8'h10);
        frame_start(sw);
        check("part_noswap", {15'd0, sw}, 16'd0);
        pix("part_unchanged", 1, 354, 1'b1, TR);
        feed(524, 1'b0, 8'h10);
        check("part_capfull", {15'd0, cap_full}, 16'd1);
        @(negedge clk);
        vs_in = 1'b0; sample_valid = 1'b1; sample_data = 8'hAA;
        @(posedge clk); #1;
        check("disc_swap", {15'd0, frame_swap}, 16'd1);
        @(negedge clk);
        vs_in = 1'b1; sample_valid = 1'b0;
        pix("part_new339", 1, 339, 1'b1, TR);
        pix("part_old354", 1, 354, 1'b1, BK);

        // Next record: 0x40 (row 291) at address 0, then 0x10
        feed(1, 1'b0, 8'h40);
        feed(1023, 1'b0, 8'h10);
        hold = 1'b1;
        for (int f = 0; f < 3; f++) begin
            frame_start(sw);
            check("hold_noswap", {15'd0, sw}, 16'd0);
            pix("hold_x1_339", 1, 339, 1'b1, TR);
            pix("hold_x1_291", 1, 291, 1'b1, BK);
        end
        check("hold_capfull", {15'd0, cap_full}, 16'd1);
        hold = 1'b0;
        frame_start(sw);
        check("release_swap", {15'd0, sw}, 16'd1);
        pix("disc_addr0", 1, 291, 1'b1, TR);
        pix("disc_noAA", 1, 185, 1'b1, BK);
        pix("disc_addr1", 2, 339, 1'b1, TR);

`ifdef GRID_EN
        pix("grid_empty", 64, 10, 1'b1, 16'h4208);
`else
        pix("grid_empty", 64, 10, 1'b1, BK);
`endif
        pix("grid_trace", 64, 339, 1'b1, TR);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
